// File: rtl/counter_seq_pkg.sv
// -----------------------------------------------------------------------------
// counter_seq_pkg
//   Shared types and constants for the counter sequencer slice.
//   - state_t     : sequencer FSM state (2-bit encoding)
//   - DIR_* /MODE_* : encodings of the cfg_dir / cfg_mode control bits
//   - cfg_t       : latched run configuration {init, term, dir, mode, div}
//   - CFG_RESET   : configuration loaded on reset
//   - is_busy()   : true while a run is in progress (RUN or PAUSE)
// -----------------------------------------------------------------------------
package counter_seq_pkg;

    // Field widths of cfg_t; counter_sequencer checks its parameters match.
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PRE_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 2'd3
    } state_t;

    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    typedef struct packed {
        logic [CNT_W-1:0] init;
        logic [CNT_W-1:0] term;
        logic             dir;
        logic             mode;
        logic [PRE_W-1:0] div;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{
        init: {CNT_W{1'b0}},
        term: {CNT_W{1'b1}},
        dir:  DIR_UP,
        mode: MODE_ONESHOT,
        div:  {PRE_W{1'b0}}
    };

    function automatic logic is_busy(state_t s);
        return (s == StRun) || (s == StPause);
    endfunction

endpackage

// File: rtl/count_core.sv
// -----------------------------------------------------------------------------
// count_core
//   WIDTH-bit synchronous up/down counter. Load has priority over count.
//   Wraps modulo 2^WIDTH in both directions.
// Ports:
//   clk      : clock
//   rst      : synchronous active-low reset, clears count
//   load     : load load_val on the next edge
//   load_val : value to load
//   en       : step by one on the next edge (ignored while load is high)
//   dir      : 0 = up, 1 = down
//   count    : current counter value
// -----------------------------------------------------------------------------
module count_core #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = dir ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//   Run controller for a WIDTH-bit up/down counter: configuration registers,
//   prescaler, terminal-count detection, one-shot / auto-reload, done/ack.
// Ports:
//   clk       : clock
//   rst       : synchronous active-low reset
//   cfg_we    : write cfg_* fields (honoured in IDLE only, else cfg_err)
//   cfg_init  : value loaded into the counter at start / reload
//   cfg_term  : terminal count value
//   cfg_dir   : 0 = up, 1 = down
//   cfg_mode  : 0 = one-shot, 1 = auto-reload
//   cfg_div   : tick every cfg_div+1 clocks
//   start     : begin a run (IDLE only)
//   pause     : level, freezes count and prescaler during a run
//   stop      : abort to IDLE from any state
//   done_ack  : leave DONE
//   count     : counter value
//   busy      : RUN or PAUSE
//   tc        : one-cycle pulse on the terminal tick
//   done      : high while in DONE
//   cfg_err   : one-cycle pulse for cfg_we outside IDLE
// Priority within a cycle: rst > stop > pause > tick > start.
// -----------------------------------------------------------------------------
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W,
    parameter int unsigned DIV_W = PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_init,
    input  logic [WIDTH-1:0] cfg_term,
    input  logic             cfg_dir,
    input  logic             cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             done_ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             cfg_err
);

    // cfg_t is sized by the package; the parameters must agree with it.
    if (WIDTH != CNT_W || DIV_W != PRE_W) begin : g_width_check
        $error("counter_sequencer: WIDTH/DIV_W must match counter_seq_pkg");
    end

    state_t           state_q, state_d;
    cfg_t             cfg_q, cfg_d;
    cfg_t             cfg_wr;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tc_q, tc_d;
    logic             cfg_err_q, cfg_err_d;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_en;

    logic             idle_wr;
    logic             tick;
    logic             at_term;

    // Configuration as presented on the inputs this cycle.
    always_comb begin
        cfg_wr      = CFG_RESET;
        cfg_wr.init = cfg_init;
        cfg_wr.term = cfg_term;
        cfg_wr.dir  = cfg_dir;
        cfg_wr.mode = cfg_mode;
        cfg_wr.div  = cfg_div;
    end

    assign idle_wr = cfg_we && (state_q == StIdle);
    assign at_term = (count == cfg_q.term);
    // stop and pause both suppress the tick in the cycle they are seen.
    assign tick    = (state_q == StRun) && !stop && !pause && (presc_q == cfg_q.div);

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cfg_q     <= CFG_RESET;
            presc_q   <= '0;
            tc_q      <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            presc_q   <= presc_d;
            tc_q      <= tc_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) state_d = StRun;
                end
                StRun: begin
                    if (pause) begin
                        state_d = StPause;
                    end else if (tick && at_term && (cfg_q.mode == MODE_ONESHOT)) begin
                        state_d = StDone;
                    end
                end
                StPause: begin
                    if (!pause) state_d = StRun;
                end
                StDone: begin
                    if (done_ack) state_d = StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath controls and registered-output next values
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_d         = idle_wr ? cfg_wr : cfg_q;
        cfg_err_d     = cfg_we && (state_q != StIdle);
        presc_d       = presc_q;
        tc_d          = 1'b0;
        core_load     = 1'b0;
        core_load_val = cfg_q.init;
        core_en       = 1'b0;

        if (stop) begin
            presc_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        // A same-cycle cfg write is visible to this start.
                        core_load     = 1'b1;
                        core_load_val = cfg_d.init;
                        presc_d       = '0;
                    end
                end
                StRun: begin
                    if (tick) begin
                        presc_d = '0;
                        if (at_term) begin
                            tc_d = 1'b1;
                            // One-shot holds count; reload restarts from init.
                            core_load = (cfg_q.mode == MODE_RELOAD);
                        end else begin
                            core_en = 1'b1;
                        end
                    end else if (!pause) begin
                        presc_d = presc_q + DIV_W'(1);
                    end
                end
                StPause, StDone: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy    = is_busy(state_q);
        done    = (state_q == StDone);
        tc      = tc_q;
        cfg_err = cfg_err_q;
    end

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .dir      (cfg_q.dir),
        .count    (count)
    );

endmodule

// File: tb/tb_counter_sequencer.sv
// -----------------------------------------------------------------------------
// tb_counter_sequencer
//   Directed vector table for the scripted scenarios, then randomized stimulus
//   checked against a behavioural model of the run rules.
// -----------------------------------------------------------------------------
module tb_counter_sequencer;

    localparam int W   = 4;
    localparam int DW  = 4;
    localparam int MOD = 1 << W;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [W-1:0]  cfg_init;
    logic [W-1:0]  cfg_term;
    logic          cfg_dir;
    logic          cfg_mode;
    logic [DW-1:0] cfg_div;
    logic          start;
    logic          pause;
    logic          stop;
    logic          done_ack;
    logic [W-1:0]  count;
    logic          busy;
    logic          tc;
    logic          done;
    logic          cfg_err;

    int errors = 0;
    int checks = 0;

    counter_sequencer #(
        .WIDTH(W),
        .DIV_W(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_init (cfg_init),
        .cfg_term (cfg_term),
        .cfg_dir  (cfg_dir),
        .cfg_mode (cfg_mode),
        .cfg_div  (cfg_div),
        .start    (start),
        .pause    (pause),
        .stop     (stop),
        .done_ack (done_ack),
        .count    (count),
        .busy     (busy),
        .tc       (tc),
        .done     (done),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // ------------------------------------------------------------------ table
    typedef struct {
        int rst, we, init, term, dir, mode, div, start, pause, stop, ack;
        int e_cnt, e_busy, e_done, e_tc, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int we, int ini, int trm, int dr, int md, int dv,
                                int st, int pa, int sp, int ak,
                                int ec, int eb, int ed, int et, int ee);
        vec_t v;
        v.rst = r; v.we = we; v.init = ini; v.term = trm; v.dir = dr; v.mode = md;
        v.div = dv; v.start = st; v.pause = pa; v.stop = sp; v.ack = ak;
        v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_tc = et; v.e_err = ee;
        return v;
    endfunction

    // Plain cycle with no control inputs asserted.
    function automatic vec_t nop(int ec, int eb, int ed, int et);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec, eb, ed, et, 0);
    endfunction

    task automatic drive(input int r, input int we, input int ini, input int trm,
                         input int dr, input int md, input int dv, input int st,
                         input int pa, input int sp, input int ak);
        rst      = r[0];
        cfg_we   = we[0];
        cfg_init = ini[W-1:0];
        cfg_term = trm[W-1:0];
        cfg_dir  = dr[0];
        cfg_mode = md[0];
        cfg_div  = dv[DW-1:0];
        start    = st[0];
        pause    = pa[0];
        stop     = sp[0];
        done_ack = ak[0];
    endtask

    task automatic build_table();
        // One-shot up 3..7, div 0
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));   // reset
        vecs.push_back(mk(1,1,3,7,0,0,0,0,0,0,0, 0,0,0,0,0));   // configure
        vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 3,1,0,0,0));   // start
        vecs.push_back(nop(4,1,0,0));
        vecs.push_back(nop(5,1,0,0));
        vecs.push_back(nop(6,1,0,0));
        vecs.push_back(nop(7,1,0,0));
        vecs.push_back(nop(7,0,1,1));                            // terminal tick
        vecs.push_back(nop(7,0,1,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 7,0,0,0,0));   // ack
        // Auto-reload down 1 -> 14, div 2, cfg+start together
        vecs.push_back(mk(1,1,1,14,1,1,2,1,0,0,0, 1,1,0,0,0));
        vecs.push_back(nop(1,1,0,0));
        vecs.push_back(nop(1,1,0,0));
        vecs.push_back(nop(0,1,0,0));
        vecs.push_back(nop(0,1,0,0));
        vecs.push_back(nop(0,1,0,0));
        vecs.push_back(nop(15,1,0,0));
        vecs.push_back(nop(15,1,0,0));
        vecs.push_back(nop(15,1,0,0));
        vecs.push_back(nop(14,1,0,0));
        vecs.push_back(nop(14,1,0,0));
        vecs.push_back(nop(14,1,0,0));
        vecs.push_back(nop(1,1,0,1));                            // reload
        vecs.push_back(nop(1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 1,0,0,0,0));   // stop
        // Pause hold at 2
        vecs.push_back(mk(1,1,0,15,0,0,0,1,0,0,0, 0,1,0,0,0));
        vecs.push_back(nop(1,1,0,0));
        vecs.push_back(nop(2,1,0,0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0,0,0,0,0,1,0,0, 2,1,0,0,0));
        vecs.push_back(nop(2,1,0,0));                            // leave PAUSE
        vecs.push_back(nop(3,1,0,0));
        // cfg write during RUN: error pulse, fields unchanged
        vecs.push_back(mk(1,1,9,5,1,1,3,0,0,0,0, 4,1,0,0,1));
        vecs.push_back(nop(5,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 5,0,0,0,0));   // stop
        vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 0,1,0,0,0));   // init still 0
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 0,0,0,0,0));
        vecs.push_back(mk(1,1,3,7,0,0,0,1,0,0,0, 3,1,0,0,0));
        vecs.push_back(mk(1,1,9,5,1,0,0,0,0,0,0, 4,1,0,0,1));   // rejected write
        vecs.push_back(nop(5,1,0,0));
        vecs.push_back(nop(6,1,0,0));                            // not term 5
        vecs.push_back(nop(7,1,0,0));
        vecs.push_back(nop(7,0,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 7,0,0,0,0));
        // stop on the terminal tick
        vecs.push_back(mk(1,1,5,6,0,0,0,1,0,0,0, 5,1,0,0,0));
        vecs.push_back(nop(6,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 6,0,0,0,0));
        vecs.push_back(nop(6,0,0,0));
        // mid-run reset, then defaults
        vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 5,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 0,1,0,0,0));
        vecs.push_back(nop(1,1,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 1,0,0,0,0));
        // start + stop in IDLE
        vecs.push_back(mk(1,0,0,0,0,0,0,1,0,1,0, 1,0,0,0,0));
        vecs.push_back(nop(1,0,0,0));
        // init == term ends on first tick; start/cfg_we in DONE
        vecs.push_back(mk(1,1,9,9,0,0,0,1,0,0,0, 9,1,0,0,0));
        vecs.push_back(nop(9,0,1,1));
        vecs.push_back(mk(1,1,2,2,0,0,0,1,0,0,0, 9,0,1,0,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 9,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,1,0,0,0, 9,1,0,0,0));
        vecs.push_back(nop(9,0,1,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1, 9,0,0,0,0));
    endtask

    // ------------------------------------------------------------------ model
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    int m_st, m_cnt, m_pre, m_init, m_term, m_dir, m_mode, m_div, m_tc, m_err;

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        if (!rst) begin
            m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_tc = 0; m_err = 0;
            m_init = 0; m_term = MOD - 1; m_dir = 0; m_mode = 0; m_div = 0;
            return;
        end
        m_tc  = 0;
        m_err = (cfg_we && m_st != M_IDLE) ? 1 : 0;
        if (cfg_we && m_st == M_IDLE) begin
            m_init = cfg_init; m_term = cfg_term; m_dir = cfg_dir;
            m_mode = cfg_mode; m_div = cfg_div;
        end
        if (stop) begin
            m_st  = M_IDLE;
            m_pre = 0;
        end else begin
            case (m_st)
                M_IDLE: if (start) begin
                    m_cnt = m_init; m_pre = 0; m_st = M_RUN;
                end
                M_RUN: begin
                    if (pause) begin
                        m_st = M_PAUSE;
                    end else if (m_pre == m_div) begin
                        m_pre = 0;
                        if (m_cnt == m_term) begin
                            m_tc = 1;
                            if (m_mode != 0) m_cnt = m_init;
                            else m_st = M_DONE;
                        end else begin
                            m_cnt = (m_cnt + (m_dir != 0 ? MOD - 1 : 1)) % MOD;
                        end
                    end else begin
                        m_pre = m_pre + 1;
                    end
                end
                M_PAUSE: if (!pause) m_st = M_RUN;
                M_DONE:  if (done_ack) m_st = M_IDLE;
                default: m_st = M_IDLE;
            endcase
        end
    endfunction

    // ------------------------------------------------------------------ main
    initial begin
        drive(0,0,0,0,0,0,0,0,0,0,0);
        build_table();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].init, vecs[i].term, vecs[i].dir,
                  vecs[i].mode, vecs[i].div, vecs[i].start, vecs[i].pause,
                  vecs[i].stop, vecs[i].ack);
            @(posedge clk);
            #1;
            check($sformatf("row%0d count", i),   int'(count),   vecs[i].e_cnt);
            check($sformatf("row%0d busy", i),    int'(busy),    vecs[i].e_busy);
            check($sformatf("row%0d done", i),    int'(done),    vecs[i].e_done);
            check($sformatf("row%0d tc", i),      int'(tc),      vecs[i].e_tc);
            check($sformatf("row%0d cfg_err", i), int'(cfg_err), vecs[i].e_err);
        end

        // Randomized phase, starting from a reset shared by model and DUT.
        drive(0,0,0,0,0,0,0,0,0,0,0);
        for (int n = 0; n < 3000; n++) begin
            if (n != 0) begin
                rst      = ($urandom_range(0, 79) != 0);
                cfg_we   = ($urandom_range(0, 7) == 0);
                cfg_init = W'($urandom);
                cfg_term = W'($urandom);
                cfg_dir  = 1'($urandom);
                cfg_mode = 1'($urandom);
                cfg_div  = DW'($urandom_range(0, 3));
                start    = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 5) == 0) pause = ~pause;
                stop     = ($urandom_range(0, 39) == 0);
                done_ack = ($urandom_range(0, 3) == 0);
            end
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d count", n),   int'(count),   m_cnt);
            check($sformatf("rnd%0d busy", n),    int'(busy),
                  (m_st == M_RUN || m_st == M_PAUSE) ? 1 : 0);
            check($sformatf("rnd%0d done", n),    int'(done),    (m_st == M_DONE) ? 1 : 0);
            check($sformatf("rnd%0d tc", n),      int'(tc),      m_tc);
            check($sformatf("rnd%0d cfg_err", n), int'(cfg_err), m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Controller that configures, starts, pauses, stops and completes runs of a WIDTH-bit up/down counter datapath. It provides a programmable prescaler, a terminal-count value, one-shot or auto-reload mode, and a done/ack handshake. It sits between a host control interface and the counter core, and is the fully synchronous replacement for ripple-style counters.

Parameters:
WIDTH, 4, counter width in bits
DIV_W, 4, prescaler divide-field width

Ports:
clk  in  1  single clock; all state updates on posedge clk
rst  in  1  reset; synchronous, active-low (asserted when 0, sampled on posedge clk)
cfg_we  in  1  write config fields below; honoured only in IDLE
cfg_init  in  WIDTH  value loaded into counter at start/reload
cfg_term  in  WIDTH  terminal count value
cfg_dir  in  1  0 = up, 1 = down
cfg_mode  in  1  0 = one-shot, 1 = auto-reload
cfg_div  in  DIV_W  tick every cfg_div+1 clocks
start  in  1  begin run (IDLE only)
pause  in  1  level; holds count while high during RUN
stop  in  1  abort to IDLE from any state
done_ack  in  1  clears DONE
count  out  WIDTH  current counter value
busy  out  1  high in RUN or PAUSE
tc  out  1  one-cycle pulse on the tick where count==cfg_term
done  out  1  high while in DONE
cfg_err  out  1  one-cycle pulse when cfg_we is seen outside IDLE

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, count=0, prescaler=0, tc=0, done=0, busy=0, cfg_err=0. Config defaults: init=0, term=all-ones, dir=up, mode=one-shot, div=0.
- States: IDLE, RUN, PAUSE, DONE. Encoding is in a 2-bit enum.
- IDLE:
  - cfg_we latches all cfg_* fields on the next edge.
  - start latches count<=cfg_init and prescaler<=0, then moves to RUN. The first tick occurs cfg_div+1 cycles later.
  - If cfg_we and start arrive in the same cycle, start uses the newly written values.
- RUN:
  - The prescaler increments every cycle. When prescaler==cfg_div, a tick fires and the prescaler returns to 0.
  - On a tick with count!=cfg_term: count +1 (up) or -1 (down), modulo 2^WIDTH (15+1 -> 0, 0-1 -> 15).
  - On a tick with count==cfg_term: tc pulses. In auto-reload mode, count<=cfg_init and the state stays RUN. In one-shot mode, count holds and the state moves to DONE.
- PAUSE:
  - pause=1 in RUN moves to PAUSE on the next edge. Count and prescaler freeze; no tick occurs in that cycle.
  - pause=0 in PAUSE returns to RUN, and the prescaler resumes from its frozen value.
- DONE: done=1 and busy=0. done_ack=1 moves to IDLE; count is retained.
- stop: from any state, moves to IDLE on the next edge. Count is retained, the prescaler clears, and no tc fires in that cycle.
- Priority within a cycle: rst > stop > pause > tick > start.
  - start outside IDLE is ignored.
  - start with stop in IDLE leaves the state in IDLE.
- cfg_we outside IDLE: fields are unchanged and cfg_err pulses for one cycle.
- If cfg_init==cfg_term, the run terminates on the first tick.
- Latency: all outputs are registered. tc and the transition into DONE appear on the same edge as the terminal tick.
- Mid-run reset behaves exactly as a power-on reset.

Decomposition:
- Package counter_seq_pkg holds:
  - state_t enum (IDLE, RUN, PAUSE, DONE)
  - DIR_UP/DIR_DOWN and MODE_ONESHOT/MODE_RELOAD constants
  - a cfg_t struct {init, term, dir, mode, div}
- Sub-module count_core: WIDTH-bit synchronous counter with load, load_val, en, dir inputs and count output. It is instantiated once.
- The FSM, prescaler and config registers live in counter_sequencer.

Test Plan:
- Reset, then configure init=3, term=7, up, one-shot, div=0, and start. Expect count 3,4,5,6,7 on consecutive cycles; tc pulses with count=7; done=1 until done_ack, then IDLE with count=7.
- Configure down, init=1, term=14, auto-reload, div=2, and start. Expect count 1,0,15,14, each step 3 cycles apart; tc pulses at 14; count reloads to 1 and busy stays 1.
- Run up from 0 with div=0 and hold pause high for 4 cycles after count=2. Expect count to hold at 2 for 4 cycles, then continue to 3 on the tick after pause falls.
- Assert cfg_we with term=5 during RUN. Expect cfg_err to pulse for one cycle and the run to still terminate at the original term.
- Assert stop on the same cycle as the terminal tick. Expect IDLE next cycle, no tc, done=0. Separately, assert rst=0 mid-run and expect count=0, state IDLE.
- Assert start and stop together in IDLE. Expect the state to remain IDLE and busy=0.
